// File: rtl/usb_line_pkg.sv
// USB line-state types and D+/D- decoding shared by the receive-path EOP logic.
package usb_line_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } line_state_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SE0_CNT   = 2'd1,
    BUS_RESET = 2'd2
  } eop_state_t;

  // J is D+ high at full speed and D- high at low speed; K is the opposite.
  function automatic line_state_t decode_line(input logic d_plus, input logic d_minus,
                                              input logic low_speed);
    line_state_t ls;
    case ({d_plus, d_minus})
      2'b00:   ls = LS_SE0;
      2'b11:   ls = LS_SE1;
      2'b10:   ls = low_speed ? LS_K : LS_J;
      default: ls = low_speed ? LS_J : LS_K;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_se0_counter.sv
// Saturating consecutive-SE0 sample counter with synchronous clear.
module usb_se0_counter #(
  parameter int unsigned CW  = 4,
  parameter int unsigned MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CW'(MAX))) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/eop_detect_seq.sv
// Bit-time sampled USB end-of-packet detector with malformed-EOP and bus-reset reporting.
module eop_detect_seq
  import usb_line_pkg::*;
#(
  parameter int unsigned MIN_SE0_BITS = 2,
  parameter int unsigned RESET_BITS   = 8,
  parameter bit          LOW_SPEED    = 1'b0,
  parameter int unsigned CW           = $clog2(RESET_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_plus,
  input  logic          d_minus,
  input  logic          shift_enable,
  output logic          eop,
  output logic          eop_err,
  output logic          bus_reset,
  output logic          se0_active,
  output logic [CW-1:0] se0_count
);

  eop_state_t  state;
  eop_state_t  state_next;
  line_state_t line;
  logic        eop_next;
  logic        eop_err_next;
  logic        bus_reset_next;
  logic        se0_active_next;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        reset_reached;
  logic        long_enough;

  assign line          = decode_line(d_plus, d_minus, LOW_SPEED);
  assign reset_reached = (se0_count == CW'(RESET_BITS - 1));
  assign long_enough   = (se0_count >= CW'(MIN_SE0_BITS));

  usb_se0_counter #(
    .CW  (CW),
    .MAX (RESET_BITS)
  ) u_se0_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (se0_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      eop        <= 1'b0;
      eop_err    <= 1'b0;
      bus_reset  <= 1'b0;
      se0_active <= 1'b0;
    end else begin
      state      <= state_next;
      eop        <= eop_next;
      eop_err    <= eop_err_next;
      bus_reset  <= bus_reset_next;
      se0_active <= se0_active_next;
    end
  end

  // Pulses default low so they last one clk; levels hold between bit samples.
  always_comb begin
    state_next      = state;
    eop_next        = 1'b0;
    eop_err_next    = 1'b0;
    bus_reset_next  = bus_reset;
    se0_active_next = se0_active;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    if (shift_enable) begin
      case (state)
        IDLE: begin
          if (line == LS_SE0) begin
            state_next      = SE0_CNT;
            cnt_inc         = 1'b1;
            se0_active_next = 1'b1;
          end
        end
        SE0_CNT: begin
          if (line == LS_SE0) begin
            cnt_inc = 1'b1;
            if (reset_reached) begin
              state_next      = BUS_RESET;
              bus_reset_next  = 1'b1;
              se0_active_next = 1'b0;
            end
          end else begin
            eop_next        = (line == LS_J) && long_enough;
            eop_err_next    = !((line == LS_J) && long_enough);
            state_next      = IDLE;
            cnt_clr         = 1'b1;
            se0_active_next = 1'b0;
          end
        end
        BUS_RESET: begin
          if (line == LS_SE0) begin
            cnt_inc = 1'b1;
          end else begin
            state_next     = IDLE;
            bus_reset_next = 1'b0;
            cnt_clr        = 1'b1;
          end
        end
        default: begin
          state_next      = IDLE;
          bus_reset_next  = 1'b0;
          se0_active_next = 1'b0;
          cnt_clr         = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eop_detect_seq.sv
// Full-speed and low-speed EOP detectors driven in parallel against a run-length reference model.
module tb_eop_detect_seq;

  localparam int unsigned MIN_BITS = 2;
  localparam int unsigned RST_BITS = 8;
  localparam int unsigned CW       = $clog2(RST_BITS + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_plus = 1'b1;
  logic d_minus = 1'b0;
  logic shift_enable = 1'b0;

  logic          eop_fs, eop_err_fs, bus_reset_fs, se0_active_fs;
  logic [CW-1:0] se0_count_fs;
  logic          eop_ls, eop_err_ls, bus_reset_ls, se0_active_ls;
  logic [CW-1:0] se0_count_ls;

  int n_vec = 0;
  int n_err = 0;

  // Reference state per speed (index 0 = full speed, 1 = low speed).
  int run [2];
  bit m_eop [2];
  bit m_err [2];

  always #5 clk = ~clk;

  eop_detect_seq #(.MIN_SE0_BITS(MIN_BITS), .RESET_BITS(RST_BITS), .LOW_SPEED(1'b0)) dut_fs (
    .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus), .shift_enable(shift_enable),
    .eop(eop_fs), .eop_err(eop_err_fs), .bus_reset(bus_reset_fs),
    .se0_active(se0_active_fs), .se0_count(se0_count_fs)
  );

  eop_detect_seq #(.MIN_SE0_BITS(MIN_BITS), .RESET_BITS(RST_BITS), .LOW_SPEED(1'b1)) dut_ls (
    .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus), .shift_enable(shift_enable),
    .eop(eop_ls), .eop_err(eop_err_ls), .bus_reset(bus_reset_ls),
    .se0_active(se0_active_ls), .se0_count(se0_count_ls)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // An SE0 run ending before the reset length is judged by its terminator and length.
  task automatic model_sample(input logic [1:0] ln);
    for (int s = 0; s < 2; s++) begin
      logic [1:0] j_code;
      j_code   = (s == 0) ? 2'b10 : 2'b01;
      m_eop[s] = 1'b0;
      m_err[s] = 1'b0;
      if (ln == 2'b00) begin
        if (run[s] < int'(RST_BITS)) run[s]++;
      end else begin
        if (run[s] > 0 && run[s] < int'(RST_BITS)) begin
          if (ln == j_code && run[s] >= int'(MIN_BITS)) m_eop[s] = 1'b1;
          else m_err[s] = 1'b1;
        end
        run[s] = 0;
      end
    end
  endtask

  task automatic check_all();
    bit br, act;
    br  = (run[0] == int'(RST_BITS));
    act = (run[0] > 0) && !br;
    chk("fs_eop", 8'(eop_fs), 8'(m_eop[0]));
    chk("fs_eop_err", 8'(eop_err_fs), 8'(m_err[0]));
    chk("fs_bus_reset", 8'(bus_reset_fs), 8'(br));
    chk("fs_se0_active", 8'(se0_active_fs), 8'(act));
    chk("fs_se0_count", 8'(se0_count_fs), 8'(run[0]));
    br  = (run[1] == int'(RST_BITS));
    act = (run[1] > 0) && !br;
    chk("ls_eop", 8'(eop_ls), 8'(m_eop[1]));
    chk("ls_eop_err", 8'(eop_err_ls), 8'(m_err[1]));
    chk("ls_bus_reset", 8'(bus_reset_ls), 8'(br));
    chk("ls_se0_active", 8'(se0_active_ls), 8'(act));
    chk("ls_se0_count", 8'(se0_count_ls), 8'(run[1]));
  endtask

  // One clk: drive, let the edge happen, advance the model, compare.
  task automatic cycle(input logic [1:0] ln, input logic se, input logic r);
    d_plus       = ln[1];
    d_minus      = ln[0];
    shift_enable = se;
    rst          = r;
    @(posedge clk);
    #1;
    if (r) begin
      for (int s = 0; s < 2; s++) begin
        run[s] = 0; m_eop[s] = 1'b0; m_err[s] = 1'b0;
      end
    end else if (se) begin
      model_sample(ln);
    end else begin
      for (int s = 0; s < 2; s++) begin
        m_eop[s] = 1'b0; m_err[s] = 1'b0;
      end
    end
    check_all();
  endtask

  // A bit sample followed by gap clocks whose line value must be ignored.
  task automatic sample(input logic [1:0] ln, input int gap);
    cycle(ln, 1'b1, 1'b0);
    for (int g = 0; g < gap; g++) cycle(2'($urandom_range(0, 3)), 1'b0, 1'b0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      run[s] = 0; m_eop[s] = 1'b0; m_err[s] = 1'b0;
    end

    cycle(2'b10, 1'b1, 1'b1);
    cycle(2'b00, 1'b1, 1'b1);
    cycle(2'b10, 1'b0, 1'b0);

    // Full-speed good EOP (low-speed instance sees a K terminator).
    sample(2'b00, 2); sample(2'b00, 2); sample(2'b10, 2);
    // Short SE0.
    sample(2'b00, 1); sample(2'b10, 1);
    // K and SE1 terminators.
    sample(2'b00, 1); sample(2'b00, 1); sample(2'b01, 1);
    sample(2'b00, 1); sample(2'b00, 1); sample(2'b11, 1);
    // Bus reset: 8 SE0 then 3 more, then J.
    for (int i = 0; i < 11; i++) sample(2'b00, 1);
    sample(2'b10, 2);
    // Reset mid-count with a J on the line and shift_enable high.
    sample(2'b00, 1); sample(2'b00, 1);
    cycle(2'b10, 1'b1, 1'b1);
    cycle(2'b10, 1'b0, 1'b0);
    // Low-speed good EOP with long gaps; full-speed instance sees a K.
    sample(2'b00, 20); sample(2'b00, 20); sample(2'b01, 20);
    sample(2'b00, 3); sample(2'b00, 3); sample(2'b10, 3);
    // Back-to-back packets with no gap.
    sample(2'b00, 0); sample(2'b00, 0); sample(2'b10, 0);
    sample(2'b00, 0); sample(2'b00, 0); sample(2'b10, 0);
    sample(2'b00, 0); sample(2'b00, 0); sample(2'b01, 2);

    // Random traffic biased toward SE0 runs of varied length.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ln;
      ln = ($urandom_range(0, 99) < 55) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 199) == 0) cycle(ln, 1'($urandom_range(0, 1)), 1'b1);
      else sample(ln, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
